// File: rtl/clock_assoc_cache.sv
// clock_assoc_cache: fully-associative cache with CLOCK (second-chance) replacement
//
// Write-allocate, read-no-allocate, no writeback. One request port with a
// valid/ready handshake and a fixed one-cycle response pulse.
//
// Ports:
//   clock      in   single clock, all state on posedge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  high in IDLE, low while sweeping for a victim
//   req_write  in   1 = write, 0 = read
//   req_addr   in   lookup/allocate tag
//   req_wdata  in   write data
//   resp_valid out  one-cycle pulse per accepted request
//   resp_hit   out  tag matched a valid line at lookup
//   resp_data  out  line data on a read hit, otherwise 0
//   hit_count  out  saturating hit counter   (CACHE_STATS_EN only)
//   miss_count out  saturating miss counter  (CACHE_STATS_EN only)
//
// Optional feature macro: CACHE_STATS_EN adds the statistics counters.
module clock_assoc_cache #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int ENTRIES    = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [LINE_WIDTH-1:0] resp_data
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
`endif
);
    localparam int PTR_W = $clog2(ENTRIES);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state;
    logic [ENTRIES-1:0]      valid;
    logic [ENTRIES-1:0]      ref_bit;
    logic [ADDR_WIDTH-1:0]   tag [ENTRIES];
    logic [LINE_WIDTH-1:0]   data [ENTRIES];
    logic [PTR_W-1:0]        hand;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [LINE_WIDTH-1:0]   pend_wdata;
    logic                    hit;
    logic                    any_free;
    logic [PTR_W-1:0]        hit_idx;
    logic [PTR_W-1:0]        free_idx;

    assign req_ready = (state == IDLE);

    // Descending scan so the lowest-index invalid line wins the fill.
    always_comb begin
        hit      = 1'b0;
        any_free = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == req_addr) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
            if (!valid[i]) begin
                any_free = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            valid      <= '0;
            ref_bit    <= '0;
            hand       <= '0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_data  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            if (state == IDLE) begin
                if (req_valid) begin
                    if (!req_write) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= hit;
                        resp_data  <= hit ? data[hit_idx] : '0;
                        if (hit) ref_bit[hit_idx] <= 1'b1;
                    end else if (hit) begin
                        data[hit_idx]    <= req_wdata;
                        ref_bit[hit_idx] <= 1'b1;
                        resp_valid       <= 1'b1;
                        resp_hit         <= 1'b1;
                        resp_data        <= '0;
                    end else if (any_free) begin
                        tag[free_idx]     <= req_addr;
                        data[free_idx]    <= req_wdata;
                        valid[free_idx]   <= 1'b1;
                        ref_bit[free_idx] <= 1'b1;
                        resp_valid        <= 1'b1;
                        resp_hit          <= 1'b0;
                        resp_data         <= '0;
                    end else begin
                        pend_addr  <= req_addr;
                        pend_wdata <= req_wdata;
                        state      <= SWEEP;
                    end
                end
            end else begin
                // Second chance: a referenced line loses its bit and the hand moves on.
                hand <= hand + 1'b1;
                if (ref_bit[hand]) begin
                    ref_bit[hand] <= 1'b0;
                end else begin
                    tag[hand]     <= pend_addr;
                    data[hand]    <= pend_wdata;
                    valid[hand]   <= 1'b1;
                    ref_bit[hand] <= 1'b1;
                    state         <= IDLE;
                    resp_valid    <= 1'b1;
                    resp_hit      <= 1'b0;
                    resp_data     <= '0;
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Counts follow the registered response, so they update the cycle after each pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (resp_valid) begin
            if (resp_hit && hit_count != '1) hit_count <= hit_count + 1'b1;
            if (!resp_hit && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_assoc_cache.sv
// tb_clock_assoc_cache: scoreboard bench for clock_assoc_cache (ENTRIES=4, 8-bit tags, 32-bit lines)
module tb_clock_assoc_cache;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_data;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total    = 0;

    clock_assoc_cache #(
        .ADDR_WIDTH(8),
        .LINE_WIDTH(32),
        .ENTRIES(4),
        .STAT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_hit(resp_hit),
        .resp_data(resp_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
                chk("resp_data", resp_data, e.data);
            end
        end
    end

    task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic eh, input logic [31:0] ed, input int exp_sweep);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        exp_q.push_back('{hit: eh, data: ed});
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("sweep_cycles", n, exp_sweep);
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        // read miss on empty cache, and no allocation afterwards
        do_req(0, 8'h10, 0, 0, 0, 0);
        do_req(0, 8'h10, 0, 0, 0, 0);
        // fill all four lines
        for (int i = 1; i <= 4; i++) do_req(1, 8'(i), 32'hA0 + i, 0, 0, 0);
        do_req(0, 8'h03, 0, 1, 32'hA3, 0);
        // full cache: full hand revolution, line0 evicted
        do_req(1, 8'h05, 32'hA5, 0, 0, 5);
        do_req(0, 8'h01, 0, 0, 0, 0);
        do_req(0, 8'h05, 0, 1, 32'hA5, 0);
        // second chance spares 0x02, evicts 0x03
        do_req(0, 8'h02, 0, 1, 32'hA2, 0);
        do_req(1, 8'h06, 32'hA6, 0, 0, 2);
        do_req(0, 8'h02, 0, 1, 32'hA2, 0);
        do_req(0, 8'h03, 0, 0, 0, 0);
        do_req(0, 8'h06, 0, 1, 32'hA6, 0);
        // write hit updates in place
        do_req(1, 8'h02, 32'hB2, 1, 0, 0);
        do_req(0, 8'h02, 0, 1, 32'hB2, 0);
        // every line referenced so the next miss sweeps long; reset part-way through
        do_req(0, 8'h04, 0, 1, 32'hA4, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h07;
        req_wdata = 32'hA7;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("sweep_entered", {31'd0, req_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk("sweep_still", {31'd0, req_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_resp_hit", {31'd0, resp_hit}, 32'd0);
        chk("abort_resp_data", resp_data, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_req(0, 8'h01, 0, 0, 0, 0);
        do_req(0, 8'h07, 0, 0, 0, 0);
        do_req(0, 8'h02, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
